// File: rtl/cpu_run_ctrl_if.sv
// Run-controller bus: host-side start/abort, per-core halt inputs, and the
// reset/run/status outputs of the sequencer.
interface cpu_run_ctrl_if #(
    parameter int N_CORES = 1,
    parameter int CNT_W   = 32
);
    logic               start;
    logic               abort;
    logic [N_CORES-1:0] halt_i;
    logic               core_rst;
    logic               run;
    logic               done;
    logic               timeout;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [N_CORES-1:0] halted;

    // The sequencer itself.
    modport master (
        input  start, abort, halt_i,
        output core_rst, run, done, timeout, cycle_cnt, halted
    );

    // Host / cores side.
    modport slave (
        output start, abort, halt_i,
        input  core_rst, run, done, timeout, cycle_cnt, halted
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: synthesizable run sequencer for one or more CPU cores.
// Holds the cores in reset for RST_HOLD cycles after start, lets them run
// while counting cycles, and stops on all-core halt or on the cycle limit.
module cpu_run_ctrl #(
    parameter int N_CORES    = 1,
    parameter int RST_HOLD   = 2,
    parameter int MAX_CYCLES = 100,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.master bus
);
    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam bit                TMO_EN    = (MAX_CYCLES != 0);
    // Limit is detected one count early so the terminating increment lands on MAX_CYCLES.
    localparam logic [CNT_W-1:0]  LIMIT_M1  = CNT_W'(MAX_CYCLES - 1);

    if (CNT_W < 32 && 64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_max
        $error("cpu_run_ctrl: MAX_CYCLES does not fit in CNT_W bits");
    end
    if (RST_HOLD < 1) begin : g_bad_hold
        $error("cpu_run_ctrl: RST_HOLD must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    state_t             state_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [N_CORES-1:0] halted_q;
    logic [N_CORES-1:0] halted_d;
    logic               core_rst_q;
    logic               run_q;
    logic               done_q;
    logic               tmo_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Candidate RUN-phase accumulator values; committed only while running.
    always_comb begin
        halted_d = halted_q | bus.halt_i;
        cnt_d    = sat_inc(cnt_q);
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            cnt_q      <= '0;
            halted_q   <= '0;
            core_rst_q <= 1'b1;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else if (bus.abort) begin
            // Counters stay as they are so the aborted run can be inspected.
            state_q    <= S_IDLE;
            core_rst_q <= 1'b1;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_TMO: begin
                    if (bus.start) begin
                        state_q    <= S_RESET;
                        hold_q     <= HOLD_LOAD;
                        cnt_q      <= '0;
                        halted_q   <= '0;
                        core_rst_q <= 1'b1;
                        run_q      <= 1'b0;
                        done_q     <= 1'b0;
                        tmo_q      <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (hold_q == '0) begin
                        state_q    <= S_RUN;
                        core_rst_q <= 1'b0;
                        run_q      <= 1'b1;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    halted_q <= halted_d;
                    cnt_q    <= cnt_d;
                    // All-halt takes precedence over the limit on the same cycle.
                    if (&halted_d) begin
                        state_q    <= S_DONE;
                        core_rst_q <= 1'b1;
                        run_q      <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (TMO_EN && cnt_q == LIMIT_M1) begin
                        state_q    <= S_TMO;
                        core_rst_q <= 1'b1;
                        run_q      <= 1'b0;
                        tmo_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    core_rst_q <= 1'b1;
                    run_q      <= 1'b0;
                    done_q     <= 1'b0;
                    tmo_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst  = core_rst_q;
    assign bus.run       = run_q;
    assign bus.done      = done_q;
    assign bus.timeout   = tmo_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl. Two instances with
// different parameter sets run side by side; a behavioural run model
// predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_cpu_run_ctrl;
    localparam int A_N = 2, A_HOLD = 2, A_MAX = 100, A_W = 32;
    localparam int B_N = 1, B_HOLD = 1, B_MAX = 0,   B_W = 4;
    localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_DONE = 3, P_TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.N_CORES(A_N), .CNT_W(A_W)) ifa ();
    cpu_run_ctrl_if #(.N_CORES(B_N), .CNT_W(B_W)) ifb ();

    cpu_run_ctrl #(.N_CORES(A_N), .RST_HOLD(A_HOLD), .MAX_CYCLES(A_MAX), .CNT_W(A_W))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    cpu_run_ctrl #(.N_CORES(B_N), .RST_HOLD(B_HOLD), .MAX_CYCLES(B_MAX), .CNT_W(B_W))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct packed {
        logic        core_rst;
        logic        run;
        logic        done;
        logic        tmo;
        logic [63:0] cnt;
        logic [1:0]  halted;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural run model, one slot per instance.
    int     ph[2];
    int     rleft[2];
    longint cnt[2];
    int     hmask[2];

    function automatic int hold_of(int i);
        return (i == 0) ? A_HOLD : B_HOLD;
    endfunction
    function automatic longint max_of(int i);
        return (i == 0) ? longint'(A_MAX) : longint'(B_MAX);
    endfunction
    function automatic longint cmax_of(int i);
        return (i == 0) ? ((longint'(1) << A_W) - 1) : ((longint'(1) << B_W) - 1);
    endfunction
    function automatic int all_of(int i);
        return (i == 0) ? ((1 << A_N) - 1) : ((1 << B_N) - 1);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic mdl_reset(input int i);
        ph[i]    = P_IDLE;
        rleft[i] = 0;
        cnt[i]   = 0;
        hmask[i] = 0;
    endtask

    // One clock edge of the run rules for instance i.
    task automatic mdl_step(input int i, input bit s, input bit a, input int h);
        if (a) begin
            ph[i] = P_IDLE;
        end else begin
            case (ph[i])
                P_IDLE, P_DONE, P_TMO: begin
                    if (s) begin
                        ph[i]    = P_RESET;
                        rleft[i] = hold_of(i);
                        cnt[i]   = 0;
                        hmask[i] = 0;
                    end
                end
                P_RESET: begin
                    rleft[i]--;
                    if (rleft[i] == 0) ph[i] = P_RUN;
                end
                P_RUN: begin
                    hmask[i] |= h;
                    if (cnt[i] < cmax_of(i)) cnt[i]++;
                    if (hmask[i] == all_of(i)) ph[i] = P_DONE;
                    else if (max_of(i) != 0 && cnt[i] == max_of(i)) ph[i] = P_TMO;
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t exp_of(input int i);
        exp_t e;
        e.core_rst = (ph[i] != P_RUN);
        e.run      = (ph[i] == P_RUN);
        e.done     = (ph[i] == P_DONE);
        e.tmo      = (ph[i] == P_TMO);
        e.cnt      = 64'(cnt[i]);
        e.halted   = 2'(hmask[i]);
        return e;
    endfunction

    // Advance one clock: update the model with the inputs that were applied, queue expectations.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!rst) begin
            mdl_reset(0);
            mdl_reset(1);
        end else begin
            mdl_step(0, ifa.start, ifa.abort, int'(ifa.halt_i));
            mdl_step(1, ifb.start, ifb.abort, int'(ifb.halt_i));
        end
        qa.push_back(exp_of(0));
        qb.push_back(exp_of(1));
    endtask

    task automatic idle_inputs();
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.halt_i = '0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.halt_i = '0;
    endtask

    // Drop rst between clock edges and look at the outputs before any edge arrives.
    task automatic async_reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst.A.core_rst", 64'(ifa.core_rst), 64'd1);
        check("arst.A.run",      64'(ifa.run),      64'd0);
        check("arst.A.done",     64'(ifa.done),     64'd0);
        check("arst.A.timeout",  64'(ifa.timeout),  64'd0);
        check("arst.A.cnt",      64'(ifa.cycle_cnt), 64'd0);
        check("arst.A.halted",   64'(ifa.halted),   64'd0);
        check("arst.B.core_rst", 64'(ifb.core_rst), 64'd1);
        check("arst.B.run",      64'(ifb.run),      64'd0);
        mdl_reset(0);
        mdl_reset(1);
        qa.push_back(exp_of(0));
        qb.push_back(exp_of(1));
    endtask

    // Monitor: pop one expectation per instance each cycle and compare.
    always @(negedge clk) begin
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            check("A.core_rst", 64'(ifa.core_rst),  64'(ea.core_rst));
            check("A.run",      64'(ifa.run),       64'(ea.run));
            check("A.done",     64'(ifa.done),      64'(ea.done));
            check("A.timeout",  64'(ifa.timeout),   64'(ea.tmo));
            check("A.cnt",      64'(ifa.cycle_cnt), ea.cnt);
            check("A.halted",   64'(ifa.halted),    64'(ea.halted));
        end
        if (qb.size() != 0) begin
            eb = qb.pop_front();
            check("B.core_rst", 64'(ifb.core_rst),  64'(eb.core_rst));
            check("B.run",      64'(ifb.run),       64'(eb.run));
            check("B.done",     64'(ifb.done),      64'(eb.done));
            check("B.timeout",  64'(ifb.timeout),   64'(eb.tmo));
            check("B.cnt",      64'(ifb.cycle_cnt), eb.cnt);
            check("B.halted",   64'(ifb.halted),    64'(eb.halted[0]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        mdl_reset(0);
        mdl_reset(1);
        #2 rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        check("reset.A.core_rst", 64'(ifa.core_rst),  64'd1);
        check("reset.A.cnt",      64'(ifa.cycle_cnt), 64'd0);
        check("reset.A.halted",   64'(ifa.halted),    64'd0);

        // Default-style run to timeout on A; B (no limit, 4-bit count) runs alongside.
        ifa.start = 1'b1; ifb.start = 1'b1;
        cycle();
        ifa.start = 1'b0; ifb.start = 1'b0;
        check("t1.core_rst_e0", 64'(ifa.core_rst), 64'd1);
        cycle();
        check("t1.core_rst_e1", 64'(ifa.core_rst), 64'd1);
        cycle();
        check("t1.core_rst_e2", 64'(ifa.core_rst), 64'd0);
        check("t1.run",         64'(ifa.run),      64'd1);
        for (int k = 0; k < 200 && ph[0] != P_TMO; k++) cycle();
        check("t1.timeout",  64'(ifa.timeout),   64'd1);
        check("t1.cnt",      64'(ifa.cycle_cnt), 64'd100);
        check("t1.core_rst", 64'(ifa.core_rst),  64'd1);
        check("t1.run_off",  64'(ifa.run),       64'd0);
        check("t6.cnt_sat",  64'(ifb.cycle_cnt), 64'd15);
        check("t6.run",      64'(ifb.run),       64'd1);
        check("t6.no_tmo",   64'(ifb.timeout),   64'd0);
        ifb.start = 1'b1;
        cycle();
        ifb.start = 1'b0;
        cycle();
        check("t6.start_ign_run", 64'(ifb.run),       64'd1);
        check("t6.start_ign_cnt", 64'(ifb.cycle_cnt), 64'd15);

        // Two cores halting at different times on A.
        ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        for (int k = 0; k < 200 && !(ph[0] == P_DONE || ph[0] == P_TMO); k++) begin
            cycle();
            if (ph[0] == P_RUN && cnt[0] == 10)
                check("t2.halted_early", 64'(ifa.halted), 64'd1);
            ifa.halt_i = {ph[0] == P_RUN && cnt[0] >= 24, ph[0] == P_RUN && cnt[0] == 9};
        end
        ifa.halt_i = '0;
        check("t2.done",    64'(ifa.done),      64'd1);
        check("t2.timeout", 64'(ifa.timeout),   64'd0);
        check("t2.cnt",     64'(ifa.cycle_cnt), 64'd25);
        check("t2.halted",  64'(ifa.halted),    64'd3);

        // All-halt on the limit cycle: done wins.
        ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        for (int k = 0; k < 200 && !(ph[0] == P_DONE || ph[0] == P_TMO); k++) begin
            cycle();
            ifa.halt_i = (ph[0] == P_RUN && cnt[0] == 99) ? 2'b11 : 2'b00;
        end
        ifa.halt_i = '0;
        check("t3.done",    64'(ifa.done),      64'd1);
        check("t3.timeout", 64'(ifa.timeout),   64'd0);
        check("t3.cnt",     64'(ifa.cycle_cnt), 64'd100);

        // Abort with a simultaneous start mid-run.
        ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        for (int k = 0; k < 200 && !(ph[0] == P_RUN && cnt[0] == 40); k++) cycle();
        ifa.abort = 1'b1; ifa.start = 1'b1;
        cycle();
        ifa.abort = 1'b0; ifa.start = 1'b0;
        check("t4.run",      64'(ifa.run),       64'd0);
        check("t4.core_rst", 64'(ifa.core_rst),  64'd1);
        check("t4.cnt",      64'(ifa.cycle_cnt), 64'd40);
        repeat (3) cycle();
        check("t4.stays_idle", 64'(ifa.core_rst), 64'd1);
        ifa.start = 1'b1;
        cycle();
        ifa.start = 1'b0;
        check("t4.restart_cnt", 64'(ifa.cycle_cnt), 64'd0);

        // Asynchronous reset in the middle of a run.
        for (int k = 0; k < 200 && !(ph[0] == P_RUN && cnt[0] == 20); k++) cycle();
        async_reset_mid();
        cycle();
        rst = 1'b1;
        repeat (5) cycle();
        check("t5.idle_run",      64'(ifa.run),      64'd0);
        check("t5.idle_core_rst", 64'(ifa.core_rst), 64'd1);

        // Randomized traffic on both instances.
        for (int k = 0; k < 2500; k++) begin
            ifa.start  = ($urandom_range(0, 7) == 0);
            ifa.abort  = ($urandom_range(0, 59) == 0);
            ifa.halt_i = {$urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0};
            ifb.start  = ($urandom_range(0, 5) == 0);
            ifb.abort  = ($urandom_range(0, 49) == 0);
            ifb.halt_i = ($urandom_range(0, 24) == 0);
            if (k == 1300) begin
                idle_inputs();
                async_reset_mid();
                cycle();
                rst = 1'b1;
            end else begin
                cycle();
            end
        end

        idle_inputs();
        cycle();
        @(negedge clk);
        #1;
        check("sb.drained", 64'(qa.size() + qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller for the CPU `top` core(s).
- Replaces the fixed-delay reset and fixed-duration run used in simulation with a synthesizable sequencer. It:
  - holds the core(s) in reset for a programmable number of cycles;
  - releases them and counts execution cycles;
  - terminates on all-core halt or on a cycle-limit timeout.
- Sits between the board/bench clock-reset source and one or more `top` instances. It is usable on FPGA and in simulation.

Parameters:
- N_CORES, 1, number of CPU cores controlled; width of halt_i/halted.
- RST_HOLD, 2, cycles core_rst stays asserted after start (≥1).
- MAX_CYCLES, 100, RUN-cycle limit before timeout; 0 disables timeout.
- CNT_W, 32, width of cycle_cnt (must hold MAX_CYCLES).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset of this block.
- start  in  1  one-cycle request to (re)start a run; honoured in IDLE, DONE, TMO.
- abort  in  1  force return to IDLE from any state.
- halt_i  in  N_CORES  per-core halt indication from the CPU, level, sampled only in RUN.
- core_rst  out  1  active-high reset to CPU top(s), registered.
- run  out  1  high while in RUN.
- done  out  1  high in DONE: all cores halted.
- timeout  out  1  high in TMO: limit reached before all halted.
- cycle_cnt  out  CNT_W  RUN cycles elapsed in current/last run.
- halted  out  N_CORES  sticky per-core halt flags for current/last run.

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, core_rst=1, run=0, done=0, timeout=0;
  - cycle_cnt=0, halted=0, hold counter=0.
- States: IDLE, RESET, RUN, DONE, TMO. All outputs are registered or decoded from the state register; there are no combinational paths from inputs.
- IDLE:
  - core_rst=1.
  - start=1 → RESET; the same edge clears cycle_cnt, halted, done, timeout and loads the hold counter with RST_HOLD-1.
- RESET:
  - core_rst=1. The hold counter decrements each cycle.
  - At 0 → RUN, and core_rst drops to 0 on that same edge.
  - core_rst is high for exactly RST_HOLD cycles after the start edge.
- RUN:
  - core_rst=0, run=1.
  - Each cycle: halted |= halt_i; cycle_cnt += 1 (saturates at all-ones).
  - Termination is evaluated on the updated value h = halted | halt_i:
    - h all ones → DONE.
    - else if MAX_CYCLES≠0 and cycle_cnt == MAX_CYCLES-1 (this cycle's increment makes it MAX_CYCLES) → TMO.
    - All-halt and limit in the same cycle → DONE wins; timeout stays 0.
- DONE / TMO:
  - core_rst=1 (cores frozen in reset).
  - cycle_cnt and halted are frozen; done or timeout is held high.
  - start → RESET (rerun; counters cleared as in IDLE).
- abort, any state:
  - → IDLE next edge; core_rst=1, run=0, done=0, timeout=0.
  - cycle_cnt and halted keep their values for inspection.
  - abort has priority over start and over termination in the same cycle.
- start while in RESET or RUN is ignored.
- halt_i outside RUN is ignored. Deassertion of halt_i never clears halted.
- Mid-run async reset:
  - core_rst asserts immediately (asynchronously) with the state reset.
  - No output glitches to 0 during reset.
- Width rule:
  - cycle_cnt is an unsigned CNT_W counter.
  - MAX_CYCLES > 2^CNT_W-1 is illegal; flag it with an elaboration-time $error.

Test Plan:
1. Reset, then start pulse at cycle 3, defaults:
   - core_rst high for exactly 2 cycles after the start edge, then 0.
   - run=1; halt_i stays 0.
   - Timeout after 100 RUN cycles: timeout=1, cycle_cnt=100, core_rst=1, run=0.
2. N_CORES=2:
   - halt_i[0] pulses at RUN cycle 10, halt_i[1] rises at cycle 25.
   - Expect halted=2'b01 at 11, DONE at 25, cycle_cnt=25, done=1, timeout=0.
3. Halt on limit cycle: halt_i=1 in RUN cycle 100 with MAX_CYCLES=100 → done=1, timeout=0, cycle_cnt=100.
4. abort at RUN cycle 40 with start asserted the same cycle:
   - IDLE next edge; core_rst=1, run=0, cycle_cnt=40.
   - A later start restarts with cycle_cnt=0.
5. Async reset (rst=0) mid-RUN between clock edges:
   - core_rst=1 and all flags 0 immediately.
   - After release, block stays IDLE until start.
6. MAX_CYCLES=0, CNT_W=4, halt never asserted: cycle_cnt saturates at 15, state remains RUN, timeout never asserts; then start is ignored.
